// File: rtl/period_meter_if.sv
// Measurement link between a square-wave source and the period meter.
// The meter is the master: it samples sig_in and drives the result fields.
interface period_meter_if #(
  parameter int WIDTH = 25
);
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;

  modport master (
    input  sig_in,
    output period, high_time, valid, timeout
  );

  modport slave (
    output sig_in,
    input  period, high_time, valid, timeout
  );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles,
// pulsing valid per measured period and flagging timeout when no rise arrives.
module period_meter #(
  parameter int MAX_COUNT = 27_000_000,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input logic          clk_in,
  input logic          reset,
  period_meter_if.master mif
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [WIDTH-1:0] cnt, hcnt;
  logic             load, set_to, clr_to;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mif.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Both counters restart at 1 so the rise cycle itself is part of the new period.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= ONE_W;
      hcnt <= ONE_W;
    end else begin
      if (cnt != MAX_W)
        cnt <= cnt + ONE_W;
      if (s2 && (hcnt != MAX_W))
        hcnt <= hcnt + ONE_W;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise) state_nxt = MEASURE;
      MEASURE: if (!rise && (cnt == MAX_W)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A rise arriving on the saturation cycle wins over the timeout.
  always_comb begin
    load   = 1'b0;
    set_to = 1'b0;
    clr_to = 1'b0;
    unique case (state)
      IDLE:    clr_to = rise;
      MEASURE: begin
        load   = rise;
        set_to = !rise && (cnt == MAX_W);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mif.period    <= '0;
      mif.high_time <= '0;
      mif.valid     <= 1'b0;
      mif.timeout   <= 1'b0;
    end else begin
      mif.valid <= load;
      if (load) begin
        mif.period    <= cnt;
        mif.high_time <= hcnt;
      end
      if (set_to)
        mif.timeout <= 1'b1;
      else if (clr_to)
        mif.timeout <= 1'b0;
    end
  end

endmodule
